// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped UART transmitter with TX FIFO, 8N1 (8E1 with UART_TX_PARITY_EN)
//   i_clk, i_rst_n (async, active-low)
//   i_we, i_addr[1:0], i_data[31:0]: bus write; 0=TXDATA push, 1=STATUS (i_data[2] clears overflow)
//   o_data[31:0]: STATUS at i_addr=1 {count[12:8], parity[3], overflow[2], full[1], busy[0]}, else 0
//   o_tx: registered serial line, idle high
//   Optional macro UART_TX_PARITY_EN inserts an even-parity bit after the data bits.
module uart_tx_periph #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_tx
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CPB_M1 = CPB - 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] LAST = CPB_M1[CW-1:0];
  localparam logic [AW:0] DEPTH = FIFO_DEPTH[AW:0];
`ifdef UART_TX_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] count_q;
  logic ovf_q;
  logic push, push_ok, full, pop, bit_end, busy, clr, launch;
  logic unused_data;
  assign unused_data = ^i_data[31:8];
  assign full = count_q == DEPTH;
  assign push = i_we && i_addr == 2'd0;
  assign push_ok = push && !full;
  assign clr = i_we && i_addr == 2'd1 && i_data[2];
  assign bit_end = cnt_q == LAST;
  assign busy = state_q != IDLE || count_q != '0;
  // a new frame starts from IDLE, or straight out of a finished stop bit so frames stay contiguous
  assign launch = count_q != '0 && (state_q == IDLE || (state_q == STOP && bit_end));
  assign o_tx = tx_q;
  assign o_data = i_addr == 2'd1 ? {19'd0, 5'(count_q), 4'd0, PAR, ovf_q, full, busy} : '0;
  always_comb begin
    state_d = state_q;
    cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    tx_d = tx_q;
    pop = 1'b0;
    case (state_q)
      IDLE: cnt_d = '0;
      START: if (bit_end) begin
        state_d = DATA;
        idx_d = '0;
        tx_d = shift_q[0];
      end
      DATA: if (bit_end) begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
          tx_d = ^shift_q;
`else
          state_d = STOP;
          tx_d = 1'b1;
`endif
        end else tx_d = shift_q[idx_q + 3'd1];
      end
      PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d = 1'b1;
      end
      STOP: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (launch) begin
      pop = 1'b1;
      shift_d = mem_q[rptr_q];
      tx_d = 1'b0;
      state_d = START;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      wptr_q <= push_ok ? wptr_q + 1'b1 : wptr_q;
      rptr_q <= pop ? rptr_q + 1'b1 : rptr_q;
      count_q <= count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
      ovf_q <= (ovf_q && !clr) || (push && full);
    end
  end
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wptr_q] <= i_data[7:0];
  end
endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: randomized self-checking bench for uart_tx_periph with a frame-level reference model
module tb_uart_tx_periph;
  localparam int CPB = 10;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [31:0] PARW = 32'h8;
`else
  localparam int NB = 10;
  localparam logic [31:0] PARW = 32'h0;
`endif
  localparam int FRAME = NB * CPB;
  logic clk = 1'b0;
  logic rst_n, we, tx;
  logic [1:0] addr;
  logic [31:0] wdata, rdata;
  int asserts = 0, fails = 0, cyc = 0;
  logic [7:0] wq[$], expq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_periph #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_addr(addr),
    .i_data(wdata), .o_data(rdata), .o_tx(tx)
  );

  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rx_frames(input int n);
    int t_prev, w;
    logic [10:0] got, exp;
    logic [7:0] b;
    t_prev = 0;
    for (int f = 0; f < n; f++) begin
      w = 0;
      do begin step(); w++; end while (tx !== 1'b0 && w < 2000);
      asserts++;
      if (tx !== 1'b0) begin
        fails++;
        $display("FAIL rx_start frame %0d: line=%b, required 0 within 2000 cycles", f, tx);
        return;
      end
      if (f > 0) begin
        asserts++;
        if (cyc - t_prev != FRAME) begin
          fails++;
          $display("FAIL frame_gap frame %0d: %0d cycles, required %0d", f, cyc - t_prev, FRAME);
        end
      end
      t_prev = cyc;
      repeat (4) step();
      got = '1;
      for (int i = 0; i < NB; i++) begin
        if (i > 0) repeat (CPB) step();
        got[i] = tx;
        if (addr == 2'd1) begin
          asserts++;
          if (rdata[0] !== 1'b1) begin
            fails++;
            $display("FAIL busy_in_frame frame %0d bit %0d: busy=%b, required 1", f, i, rdata[0]);
          end
        end
      end
      asserts++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_frame: got %b, required no frame", got);
      end else begin
        b = expq.pop_front();
        exp = frame_of(b);
        if (got !== exp) begin
          fails++;
          $display("FAIL frame_bits byte %h: got %b, required %b", b, got, exp);
        end
      end
    end
  endtask

  task automatic run_burst(input bit clr);
    int len, nacc;
    bit ovf_e;
    len = wq.size();
    nacc = len > DEPTH + 1 ? DEPTH + 1 : len;
    ovf_e = len > DEPTH + 1;
    expq.delete();
    for (int i = 0; i < nacc; i++) expq.push_back(wq[i]);
    fork
      begin
        for (int i = 0; i < len; i++) begin
          @(negedge clk);
          we = 1'b1;
          addr = 2'd0;
          wdata = ($urandom() & 32'hFFFF_FF00) | {24'd0, wq[i]};
        end
        @(negedge clk);
        we = 1'b0;
        addr = 2'd1;
        #1;
        if (len == 1) begin
          asserts++;
          if (tx !== 1'b1 || rdata !== (PARW | 32'h101)) begin
            fails++;
            $display("FAIL latency_edge1: tx=%b status=%h, required tx=1 status=%h", tx, rdata, PARW | 32'h101);
          end
          @(negedge clk);
          #1;
          asserts++;
          if (tx !== 1'b0) begin
            fails++;
            $display("FAIL latency_edge2: tx=%b, required 0", tx);
          end
        end else begin
          asserts++;
          if (rdata[12:8] !== 5'(nacc - 1) || rdata[1] !== (nacc - 1 == DEPTH) || rdata[2] !== ovf_e) begin
            fails++;
            $display("FAIL burst_status len %0d: count=%0d full=%b ovf=%b, required %0d %b %b",
                     len, rdata[12:8], rdata[1], rdata[2], nacc - 1, nacc - 1 == DEPTH, ovf_e);
          end
        end
        if (clr) begin
          @(negedge clk);
          we = 1'b1;
          wdata = 32'hFFFF_FFFB;
          @(negedge clk);
          we = 1'b0;
          #1;
          asserts++;
          if (rdata[2] !== ovf_e) begin
            fails++;
            $display("FAIL ovf_no_clear: ovf=%b, required %b", rdata[2], ovf_e);
          end
          @(negedge clk);
          we = 1'b1;
          wdata = 32'h4;
          @(negedge clk);
          we = 1'b0;
          #1;
          ovf_e = 1'b0;
          asserts++;
          if (rdata[2] !== 1'b0 || rdata[12:8] !== 5'(nacc - 1)) begin
            fails++;
            $display("FAIL ovf_clear: ovf=%b count=%0d, required 0 %0d", rdata[2], rdata[12:8], nacc - 1);
          end
        end
      end
      rx_frames(nacc);
    join
    repeat (6) step();
    asserts++;
    if (rdata !== (PARW | (ovf_e ? 32'h4 : 32'h0)) || tx !== 1'b1) begin
      fails++;
      $display("FAIL burst_end len %0d: status=%h tx=%b, required %h 1", len, rdata, tx, PARW | (ovf_e ? 32'h4 : 32'h0));
    end
  endtask

  task automatic test_reset();
    addr = 2'd1;
    repeat (3) step();
    asserts++;
    if (tx !== 1'b1 || rdata !== PARW) begin
      fails++;
      $display("FAIL reset_hold: tx=%b status=%h, required 1 %h", tx, rdata, PARW);
    end
    rst_n = 1'b1;
    step();
    asserts++;
    if (tx !== 1'b1 || rdata !== PARW) begin
      fails++;
      $display("FAIL reset_idle: tx=%b status=%h, required 1 %h", tx, rdata, PARW);
    end
  endtask

  task automatic test_regs();
    int lows;
    for (int a = 2; a < 4; a++) begin
      @(negedge clk);
      we = 1'b1;
      addr = 2'(a);
      wdata = $urandom();
    end
    @(negedge clk);
    we = 1'b0;
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      addr = 2'(a);
      #1;
      asserts++;
      if (rdata !== (a == 1 ? PARW : 32'h0)) begin
        fails++;
        $display("FAIL reg_read addr %0d: %h, required %h", a, rdata, a == 1 ? PARW : 32'h0);
      end
    end
    lows = 0;
    repeat (30) begin step(); if (tx !== 1'b1) lows++; end
    asserts++;
    if (lows != 0) begin
      fails++;
      $display("FAIL ignored_write_line: %0d low cycles, required 0", lows);
    end
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(2, 7);
      wq.delete();
      for (int i = 0; i < len; i++) wq.push_back(8'($urandom()));
      run_burst(len > DEPTH + 1);
    end
  endtask

  task automatic test_reset_mid();
    int w, lows;
    wq = {8'($urandom()), 8'($urandom())};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      we = 1'b1;
      addr = 2'd0;
      wdata = {24'd0, wq[i]};
    end
    @(negedge clk);
    we = 1'b0;
    addr = 2'd1;
    w = 0;
    while (tx !== 1'b0 && w < 2000) begin step(); w++; end
    repeat (4 + 4 * CPB) step();
    asserts++;
    if (tx !== wq[0][3]) begin
      fails++;
      $display("FAIL mid_frame_bit3: tx=%b, required %b", tx, wq[0][3]);
    end
    rst_n = 1'b0;
    #1;
    asserts++;
    if (tx !== 1'b1 || rdata !== PARW) begin
      fails++;
      $display("FAIL async_reset: tx=%b status=%h, required 1 %h", tx, rdata, PARW);
    end
    step();
    rst_n = 1'b1;
    lows = 0;
    repeat (300) begin step(); if (tx !== 1'b1) lows++; end
    asserts++;
    if (lows != 0 || rdata !== PARW) begin
      fails++;
      $display("FAIL after_reset: %0d low cycles status=%h, required 0 %h", lows, rdata, PARW);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    we = 1'b0;
    addr = 2'd0;
    wdata = '0;
    test_reset();
    test_regs();
    wq = {8'hA5};
    run_burst(1'b0);
    wq = {8'h55, 8'h0F, 8'hFF, 8'h00, 8'h81};
    run_burst(1'b0);
    wq = {8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66};
    run_burst(1'b1);
    test_random();
    wq = {8'h07, 8'h03};
    run_burst(1'b0);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
